seg_mux_display: RTL and testbench

//  Parametrised N-digit multiplexed seven-segment driver; successor to the fixed 3-digit core display path.

---
 rtl/seg_mux_display.sv | 201 ++++++++++++++++++++
 tb/tb_seg_mux_display.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_display.sv
// seg_mux_display: N-digit multiplexed seven-segment driver.
// A hex value arrives over a valid/ready port into a pending buffer and is
// copied to the active buffer only at frame end, so a frame never mixes two
// values. Digits are scanned round-robin; each slot is 16 sub-ticks with
// sub-tick 0 kept dark as a ghosting guard and sub-ticks 1..bright lit.
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
module seg_mux_display #(
   parameter int DIGITS         = 3,
   parameter int TICK_DIV       = 4,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int EN_ACTIVE_LOW  = 1
) (
   input  logic                  cin,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
   input  logic [3:0]            bright,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     en,
   output logic                  frame
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] EN_OFF   = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

   // scan counters
   logic [PRE_W-1:0]     r_pre;
   logic [3:0]           r_sub;
   logic [DIG_W-1:0]     r_dig;

   // double buffer
   logic [4*DIGITS-1:0]  r_pend_data;
   logic [DIGITS-1:0]    r_pend_dp;
   logic                 r_pend_full;
   logic [4*DIGITS-1:0]  r_act_data;
   logic [DIGITS-1:0]    r_act_dp;

   // per-slot state and registered outputs
   logic [3:0]           r_bright;
   logic [7:0]           r_seg;
   logic [DIGITS-1:0]    r_en;

   logic                 w_pre_wrap;
   logic                 w_sub_wrap;
   logic                 w_dig_last;
   logic                 w_frame_end;
   logic [PRE_W-1:0]     w_pre_nx;
   logic [3:0]           w_sub_nx;
   logic [DIG_W-1:0]     w_dig_nx;
   logic                 w_slot_start_nx;
   logic                 w_swap;
   logic                 w_wr_acc;
   logic [4*DIGITS-1:0]  w_act_data_nx;
   logic [DIGITS-1:0]    w_act_dp_nx;
   logic [3:0]           w_bright_nx;
   logic [3:0]           w_nibs [DIGITS];
   logic [3:0]           w_nib;
   logic                 w_dp_bit;
   logic [6:0]           w_hex7;
   logic                 w_blank;
   logic [7:0]           w_seg_pat;
   logic                 w_drive;
   logic [DIGITS-1:0]    w_onehot;
   logic [DIGITS-1:0]    w_en_pat;

   assign w_pre_wrap  = (r_pre == PRE_LAST);
   assign w_sub_wrap  = (r_sub == 4'd15);
   assign w_dig_last  = (r_dig == DIG_LAST);
   assign w_frame_end = w_pre_wrap & w_sub_wrap & w_dig_last;

   assign w_pre_nx = w_pre_wrap ? '0 : r_pre + PRE_W'(1);
   assign w_sub_nx = w_pre_wrap ? r_sub + 4'd1 : r_sub;
   assign w_dig_nx = (w_pre_wrap & w_sub_wrap) ? (w_dig_last ? '0 : r_dig + DIG_W'(1)) : r_dig;
   assign w_slot_start_nx = (w_pre_nx == '0) && (w_sub_nx == 4'd0);

   assign w_wr_acc = wr_valid & ~r_pend_full;
   assign w_swap   = w_frame_end & r_pend_full;

   // Outputs for the next cycle are computed from the post-edge state, so the
   // value swapped in at frame end is already what digit 0 decodes next.
   assign w_act_data_nx = w_swap ? r_pend_data : r_act_data;
   assign w_act_dp_nx   = w_swap ? r_pend_dp   : r_act_dp;
   assign w_bright_nx   = w_slot_start_nx ? bright : r_bright;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         assign w_nibs[gi] = w_act_data_nx[4*gi +: 4];
      end
   endgenerate

   assign w_nib    = w_nibs[w_dig_nx];
   assign w_dp_bit = w_act_dp_nx[w_dig_nx];

`ifdef SEG_LZB_EN
   // w_lz_upper[k] is set when nibbles k..DIGITS-1 are all zero.
   logic [DIGITS:0] w_lz_upper;
   assign w_lz_upper[DIGITS] = 1'b1;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_lz
         assign w_lz_upper[gi] = w_lz_upper[gi+1] & (w_nibs[gi] == 4'h0);
      end
   endgenerate
   assign w_blank = (w_dig_nx != '0) & w_lz_upper[w_dig_nx];
`else
   assign w_blank = 1'b0;
`endif

   // hex nibble to active-high {g,f,e,d,c,b,a}
   always_comb begin
      w_hex7 = 7'h00;
      case (w_nib)
         4'h0: w_hex7 = 7'h3F;
         4'h1: w_hex7 = 7'h06;
         4'h2: w_hex7 = 7'h5B;
         4'h3: w_hex7 = 7'h4F;
         4'h4: w_hex7 = 7'h66;
         4'h5: w_hex7 = 7'h6D;
         4'h6: w_hex7 = 7'h7D;
         4'h7: w_hex7 = 7'h07;
         4'h8: w_hex7 = 7'h7F;
         4'h9: w_hex7 = 7'h6F;
         4'hA: w_hex7 = 7'h77;
         4'hB: w_hex7 = 7'h7C;
         4'hC: w_hex7 = 7'h39;
         4'hD: w_hex7 = 7'h5E;
         4'hE: w_hex7 = 7'h79;
         4'hF: w_hex7 = 7'h71;
         default: w_hex7 = 7'h00;
      endcase
   end

   assign w_seg_pat = {w_dp_bit, (w_blank ? 7'h00 : w_hex7)};

   // Sub-tick 0 is never lit so segments settle before the digit is driven.
   assign w_drive  = (w_sub_nx != 4'd0) && (w_sub_nx <= w_bright_nx);
   assign w_onehot = DIGITS'(1) << w_dig_nx;
   assign w_en_pat = w_drive ? w_onehot : '0;

   // prescaler / sub-tick / digit scan counters
   always_ff @(posedge cin) begin
      if (rst) begin
         r_pre <= '0;
         r_sub <= 4'd0;
         r_dig <= '0;
      end else begin
         r_pre <= w_pre_nx;
         r_sub <= w_sub_nx;
         r_dig <= w_dig_nx;
      end
   end

   // pending/active double buffer; accept and swap never coincide because
   // accept needs pending empty and swap needs it full
   always_ff @(posedge cin) begin
      if (rst) begin
         r_pend_data <= '0;
         r_pend_dp   <= '0;
         r_pend_full <= 1'b0;
         r_act_data  <= '0;
         r_act_dp    <= '0;
      end else begin
         if (w_swap) begin
            r_act_data  <= r_pend_data;
            r_act_dp    <= r_pend_dp;
            r_pend_full <= 1'b0;
         end else if (w_wr_acc) begin
            r_pend_data <= wr_data;
            r_pend_dp   <= wr_dp;
            r_pend_full <= 1'b1;
         end
      end
   end

   // segment pattern latched at slot start; digit enable follows the duty window
   always_ff @(posedge cin) begin
      if (rst) begin
         r_bright <= 4'd0;
         r_seg    <= SEG_OFF;
         r_en     <= EN_OFF;
      end else begin
         r_bright <= w_bright_nx;
         if (w_slot_start_nx) begin
            r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_pat : w_seg_pat;
         end
         r_en <= (EN_ACTIVE_LOW != 0) ? ~w_en_pat : w_en_pat;
      end
   end

   assign wr_ready = ~r_pend_full;
   assign seg      = r_seg;
   assign en       = r_en;
   assign frame    = w_frame_end;

endmodule

// File: tb/tb_seg_mux_display.sv
// Directed bench for seg_mux_display (DIGITS=3, TICK_DIV=4, active-low).
// Cycle index t counts clock periods from the first cycle after reset release;
// expected scan position and outputs are derived from t.
module tb_seg_mux_display;

   logic        cin;
   logic        rst;
   logic        wr_valid;
   logic        wr_ready;
   logic [11:0] wr_data;
   logic [2:0]  wr_dp;
   logic [3:0]  bright;
   logic [7:0]  seg;
   logic [2:0]  en;
   logic        frame;

   int t;
   int n_tests;
   int n_fail;

   seg_mux_display #(
      .DIGITS(3),
      .TICK_DIV(4),
      .SEG_ACTIVE_LOW(1),
      .EN_ACTIVE_LOW(1)
   ) dut (
      .cin(cin),
      .rst(rst),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_data(wr_data),
      .wr_dp(wr_dp),
      .bright(bright),
      .seg(seg),
      .en(en),
      .frame(frame)
   );

   initial cin = 1'b0;
   always #5 cin = ~cin;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   function automatic logic [7:0] exp_seg(input logic [11:0] val, input logic [2:0] dp, input int d);
      logic [3:0] nib;
      logic [6:0] p;
      nib = val[d*4 +: 4];
      p   = hex7(nib);
`ifdef SEG_LZB_EN
      if (d == 2 && val[11:8] == 4'h0) p = 7'h00;
      if (d == 1 && val[11:4] == 8'h00) p = 7'h00;
`endif
      return ~{dp[d], p};
   endfunction

   task automatic cyc();
      @(negedge cin);
      t++;
   endtask

   // advance to cycle t_end, checking every cycle against the given shown value
   task automatic run_chk(input int t_end, input logic [11:0] val, input logic [2:0] dp,
                          input logic [3:0] bl);
      int d;
      int sub;
      logic [2:0] e;
      while (t < t_end) begin
         cyc();
         d   = (t / 64) % 3;
         sub = (t / 4) % 16;
         e   = (sub >= 1 && sub <= int'(bl)) ? ~(3'b001 << d) : 3'b111;
         check_val("en", {29'd0, en}, {29'd0, e});
         check_val("seg", {24'd0, seg}, {24'd0, exp_seg(val, dp, d)});
         check_val("frame", {31'd0, frame}, {31'd0, (t % 192 == 191)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge cin);
      rst = 1'b0;
      t = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_seg"}, {24'd0, seg}, 32'h0000_00FF);
      check_val({tag, "_en"}, {29'd0, en}, 32'h0000_0007);
      check_val({tag, "_rdy"}, {31'd0, wr_ready}, 32'd1);
      check_val({tag, "_frame"}, {31'd0, frame}, 32'd0);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      t        = 0;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 12'h000;
      wr_dp    = 3'b000;
      bright   = 4'd15;

      // power-up reset, run mid-scan, then a 3-cycle reset
      repeat (3) @(negedge cin);
      rst = 1'b0;
      repeat (100) @(negedge cin);
      do_reset();
      check_reset_state("rst1");

      // idle: slot 0 was latched during reset; afterwards zeros at 15/16 duty
      while (t < 63) cyc();
      run_chk(383, 12'h000, 3'b000, 4'd15);

      // write 1A5 with dp on digit 1
      run_chk(399, 12'h000, 3'b000, 4'd15);
      wr_valid = 1'b1; wr_data = 12'h1A5; wr_dp = 3'b010;
      check_val("rdy_before_wr", {31'd0, wr_ready}, 32'd1);
      run_chk(400, 12'h000, 3'b000, 4'd15);
      check_val("rdy_after_wr", {31'd0, wr_ready}, 32'd0);
      // second write while busy must be ignored
      wr_data = 12'hFFF; wr_dp = 3'b111;
      run_chk(405, 12'h000, 3'b000, 4'd15);
      wr_valid = 1'b0; wr_data = 12'h000; wr_dp = 3'b000;
      run_chk(575, 12'h000, 3'b000, 4'd15);
      check_val("rdy_hold_fe", {31'd0, wr_ready}, 32'd0);
      run_chk(576, 12'h1A5, 3'b010, 4'd15);
      check_val("rdy_after_swap", {31'd0, wr_ready}, 32'd1);
      run_chk(959, 12'h1A5, 3'b010, 4'd15);

      // brightness 0 then 4, changed just before a slot start
      bright = 4'd0;
      run_chk(1151, 12'h1A5, 3'b010, 4'd0);
      bright = 4'd4;
      run_chk(1199, 12'h1A5, 3'b010, 4'd4);

      // write 007: leading zeros (blanked only with SEG_LZB_EN)
      wr_valid = 1'b1; wr_data = 12'h007; wr_dp = 3'b000;
      run_chk(1200, 12'h1A5, 3'b010, 4'd4);
      wr_valid = 1'b0;
      run_chk(1343, 12'h1A5, 3'b010, 4'd4);
      run_chk(1535, 12'h007, 3'b000, 4'd4);

      // write accepted on the frame-end cycle shows one frame later
      wr_valid = 1'b1; wr_data = 12'h3B0; wr_dp = 3'b001;
      check_val("rdy_fe_wr", {31'd0, wr_ready}, 32'd1);
      run_chk(1536, 12'h007, 3'b000, 4'd4);
      wr_valid = 1'b0;
      check_val("rdy_fe_acc", {31'd0, wr_ready}, 32'd0);
      run_chk(1727, 12'h007, 3'b000, 4'd4);
      run_chk(1919, 12'h3B0, 3'b001, 4'd4);
      check_val("rdy_fe_swap", {31'd0, wr_ready}, 32'd1);

      // reset with pending full: pending discarded, active back to 0
      wr_valid = 1'b1; wr_data = 12'h5C9; wr_dp = 3'b100;
      run_chk(1920, 12'h3B0, 3'b001, 4'd4);
      wr_valid = 1'b0;
      check_val("rdy_pend_full", {31'd0, wr_ready}, 32'd0);
      run_chk(1950, 12'h3B0, 3'b001, 4'd4);
      do_reset();
      check_reset_state("rst2");
      while (t < 63) cyc();
      run_chk(383, 12'h000, 3'b000, 4'd4);
      check_val("rdy_post_rst", {31'd0, wr_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
